// File: rtl/sampler_pkg.sv
// Shared constants, variable layout and FSM encoding for the constraint sampler.
// The candidate is filled from 32-bit LFSR words, so the fill register is rounded up to whole words.
package sampler_pkg;

    localparam int          CAND_W     = 185;
    localparam int          NWORDS     = (CAND_W + 31) / 32;
    localparam int          FILL_W     = NWORDS * 32;
    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    localparam logic [31:0] RESET_SEED = 32'hACE1_ACE1;

    // Bit offsets and widths of var_0..var_9 inside the candidate, LSB first
    localparam int VAR0_LO = 0,   VAR0_W = 16;
    localparam int VAR1_LO = 16,  VAR1_W = 22;
    localparam int VAR2_LO = 38,  VAR2_W = 4;
    localparam int VAR3_LO = 42,  VAR3_W = 28;
    localparam int VAR4_LO = 70,  VAR4_W = 19;
    localparam int VAR5_LO = 89,  VAR5_W = 18;
    localparam int VAR6_LO = 107, VAR6_W = 19;
    localparam int VAR7_LO = 126, VAR7_W = 14;
    localparam int VAR8_LO = 140, VAR8_W = 16;
    localparam int VAR9_LO = 156, VAR9_W = 29;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_CHECK,
        S_HOLD
    } state_t;

    // Right-shifting Galois step: the bit shifted out decides whether the taps are applied
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with seed load (zero seed replaced by the reset value) and step enable.
// `next` is the value the register takes on the next step, so callers can use it the same cycle.
module lfsr32
    import sampler_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = RESET_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] next
);

    logic [31:0] state;

    assign next = lfsr_next(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_VAL;
        end else if (load) begin
            // An all-zero state would lock the LFSR up, so zero seeds fall back to the reset value
            state <= (seed == 32'h0) ? RESET_VAL : seed;
        end else if (step) begin
            state <= next;
        end
    end

endmodule

// File: rtl/constraint_sampler.sv
// Generates LFSR-filled candidates, presents them to an external constraint checker and
// hands accepted ones out through a valid/ready port; gives up after MAX_TRIES rejections.
module constraint_sampler
    import sampler_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [31:0]       seed,
    input  logic              start,
    output logic [CAND_W-1:0] cand,
    input  logic              chk_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CAND_W-1:0] sample,
    output logic              busy,
    output logic              fail,
    output logic [15:0]       tries
);

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_q;
    logic [2:0]          cnt_q;
    logic [15:0]         tries_q;
    logic [15:0]         tries_inc;
    logic [CAND_W-1:0]   sample_q;
    logic                fail_q, fail_d;
    logic                lfsr_load, lfsr_step;
    logic                clr_tries, inc_tries, capture;
    logic [31:0]         lfsr_nxt;

    lfsr32 #(
        .RESET_VAL (RESET_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .next  (lfsr_nxt)
    );

    assign tries_inc = tries_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        clr_tries = 1'b0;
        inc_tries = 1'b0;
        capture   = 1'b0;
        fail_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A same-cycle seed_load lands before the first FILL step, so start uses the new seed
                lfsr_load = seed_load;
                if (start) begin
                    clr_tries = 1'b1;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                lfsr_step = 1'b1;
                if (cnt_q == 3'(NWORDS - 1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                inc_tries = 1'b1;
                if (chk_ok) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end else if (tries_inc == 16'(MAX_TRIES)) begin
                    fail_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            fill_q   <= '0;
            cnt_q    <= '0;
            tries_q  <= '0;
            sample_q <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            // The counter only runs while filling, so every FILL burst starts from zero
            cnt_q   <= (state_q == S_FILL) ? cnt_q + 3'd1 : 3'd0;
            if (lfsr_step) begin
                fill_q <= {lfsr_nxt, fill_q[FILL_W-1:32]};
            end
            if (clr_tries) begin
                tries_q <= '0;
            end else if (inc_tries) begin
                tries_q <= tries_inc;
            end
            if (capture) begin
                sample_q <= fill_q[CAND_W-1:0];
            end
        end
    end

    assign cand      = fill_q[CAND_W-1:0];
    assign sample    = sample_q;
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_IDLE);
    assign fail      = fail_q;
    assign tries     = tries_q;

endmodule

// File: tb/tb_constraint_sampler.sv
// Scoreboard bench for constraint_sampler: an independent LFSR model predicts every accepted
// candidate, and each scenario task checks timing, handshake and reset behaviour inline.
module tb_constraint_sampler;

    localparam int CW = 185;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          seed_load;
    logic [31:0]   seed;
    logic          start;
    logic [CW-1:0] cand;
    logic          chk_ok;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] sample;
    logic          busy;
    logic          fail;
    logic [15:0]   tries;

    int vectors = 0;
    int miscompares = 0;

    logic [191:0] exp_q[$];
    logic [31:0]  m_lfsr;

    constraint_sampler #(.MAX_TRIES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .start     (start),
        .cand      (cand),
        .chk_ok    (chk_ok),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sample    (sample),
        .busy      (busy),
        .fail      (fail),
        .tries     (tries)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] t;
        t = {1'b0, s[31:1]};
        if (s[0] == 1'b1) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    task automatic gen_cand(output logic [191:0] c);
        c = '0;
        for (int i = 0; i < 6; i++) begin
            m_lfsr = m_step(m_lfsr);
            c[i*32 +: 32] = m_lfsr;
        end
    endtask

    // Ticks until out_valid rises; edges = -1 if the budget runs out
    task automatic wait_valid(input int limit, output int edges);
        edges = -1;
        for (int e = 1; e <= limit; e++) begin
            tick();
            if (out_valid === 1'b1) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic check_sample_pop(input string name);
        logic [191:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty, got sample %h", name, sample);
        end else begin
            e = exp_q.pop_front();
            if (sample !== e[CW-1:0]) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", name, sample, e[CW-1:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; seed_load = 1'b0; seed = '0; start = 1'b0; chk_ok = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (tries !== 16'd0) begin miscompares++; $display("FAIL reset_tries: got %0d expected 0", tries); end
        vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL reset_fail: got %b expected 0", fail); end
        vectors++; if (cand !== '0) begin miscompares++; $display("FAIL reset_cand: got %h expected 0", cand); end
        vectors++; if (sample !== '0) begin miscompares++; $display("FAIL reset_sample: got %h expected 0", sample); end
        rst_n = 1'b1;
        m_lfsr = 32'hACE1_ACE1;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_seed1_accept();
        logic [191:0] c;
        logic early;
        seed = 32'd1; seed_load = 1'b1; start = 1'b1; chk_ok = 1'b1; out_ready = 1'b0;
        m_lfsr = 32'd1;
        gen_cand(c);
        exp_q.push_back(c);
        tick();
        seed_load = 1'b0; start = 1'b0;
        early = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (out_valid !== 1'b0) early = 1'b1;
        end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL early_valid: got %b expected 0", early); end
        tick();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL valid_edge7: got %b expected 1", out_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL hold_busy: got %b expected 1", busy); end
        vectors++; if (tries !== 16'd1) begin miscompares++; $display("FAIL tries_one: got %0d expected 1", tries); end
        vectors++; if (sample[31:0] !== 32'h8020_0003) begin miscompares++; $display("FAIL word0: got %h expected 80200003", sample[31:0]); end
        vectors++; if (sample[63:32] !== 32'hC030_0002) begin miscompares++; $display("FAIL word1: got %h expected c0300002", sample[63:32]); end
        vectors++; if (sample[15:0] !== 16'h0003) begin miscompares++; $display("FAIL var_0: got %h expected 0003", sample[15:0]); end
        vectors++; if (sample[37:16] !== 22'h028020) begin miscompares++; $display("FAIL var_1: got %h expected 028020", sample[37:16]); end
        check_sample_pop("seed1_sample");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL handshake_idle: got valid %b busy %b expected 0 0", out_valid, busy); end
        vectors++; if (tries !== 16'd1) begin miscompares++; $display("FAIL tries_hold_idle: got %0d expected 1", tries); end
    endtask

    task automatic test_seed_zero();
        logic [191:0] c;
        int edges;
        seed = 32'd0; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b1; chk_ok = 1'b1;
        m_lfsr = 32'hACE1_ACE1;
        gen_cand(c);
        exp_q.push_back(c);
        tick();
        start = 1'b0;
        wait_valid(20, edges);
        vectors++; if (edges != 7) begin miscompares++; $display("FAIL seed0_latency: got %0d expected 7", edges); end
        vectors++; if (sample[31:0] !== 32'hD650_D673) begin miscompares++; $display("FAIL seed0_word0: got %h expected d650d673", sample[31:0]); end
        check_sample_pop("seed0_sample");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_fail();
        logic [191:0] c;
        int fail_edge;
        logic saw_valid, busy_at_fail, fail_next;
        logic [15:0] tries_at_fail;
        chk_ok = 1'b0; start = 1'b1;
        for (int k = 0; k < 16; k++) gen_cand(c);
        tick();
        start = 1'b0;
        fail_edge = -1; saw_valid = 1'b0; busy_at_fail = 1'bx; fail_next = 1'bx; tries_at_fail = 'x;
        for (int e = 1; e <= 130; e++) begin
            tick();
            if (out_valid === 1'b1) saw_valid = 1'b1;
            if (fail_edge >= 0 && e == fail_edge + 1) begin
                fail_next = fail;
                break;
            end
            if (fail === 1'b1 && fail_edge < 0) begin
                fail_edge = e; busy_at_fail = busy; tries_at_fail = tries;
            end
        end
        vectors++; if (fail_edge != 112) begin miscompares++; $display("FAIL fail_edge: got %0d expected 112", fail_edge); end
        vectors++; if (saw_valid !== 1'b0) begin miscompares++; $display("FAIL fail_no_valid: got %b expected 0", saw_valid); end
        vectors++; if (busy_at_fail !== 1'b0) begin miscompares++; $display("FAIL fail_busy: got %b expected 0", busy_at_fail); end
        vectors++; if (tries_at_fail !== 16'd16) begin miscompares++; $display("FAIL fail_tries: got %0d expected 16", tries_at_fail); end
        vectors++; if (fail_next !== 1'b0) begin miscompares++; $display("FAIL fail_pulse_width: got %b expected 0", fail_next); end
        vectors++; if (tries !== 16'd16 || busy !== 1'b0) begin miscompares++; $display("FAIL fail_after: got tries %0d busy %b expected 16 0", tries, busy); end
    endtask

    task automatic test_retry();
        logic [191:0] c;
        int first_valid;
        chk_ok = 1'b0; start = 1'b1;
        gen_cand(c); gen_cand(c); gen_cand(c);
        exp_q.push_back(c);
        tick();
        start = 1'b0;
        first_valid = -1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 14) chk_ok = 1'b1;
            if (out_valid === 1'b1) begin
                first_valid = e;
                break;
            end
        end
        vectors++; if (first_valid != 21) begin miscompares++; $display("FAIL retry_latency: got %0d expected 21", first_valid); end
        vectors++; if (tries !== 16'd3) begin miscompares++; $display("FAIL retry_tries: got %0d expected 3", tries); end
        check_sample_pop("retry_sample");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        logic [191:0] c;
        int edges;
        logic stable;
        chk_ok = 1'b1; start = 1'b1;
        gen_cand(c);
        tick();
        start = 1'b0;
        wait_valid(20, edges);
        vectors++; if (edges != 7) begin miscompares++; $display("FAIL hold_latency: got %0d expected 7", edges); end
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            tick();
            stable = (out_valid === 1'b1) && (busy === 1'b1) && (sample === c[CW-1:0]) && (tries === 16'd1);
            vectors++;
            if (!stable) begin
                miscompares++;
                $display("FAIL hold_stable[%0d]: got valid %b sample %h expected 1 %h", i, out_valid, sample, c[CW-1:0]);
            end
        end
        start = 1'b0; out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL hold_release: got valid %b busy %b expected 0 0", out_valid, busy); end
        tick();
        tick();
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_ready: got valid %b busy %b expected 0 0", out_valid, busy); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [191:0] c;
        int edges;
        chk_ok = 1'b1; out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            gen_cand(c);
            exp_q.push_back(c);
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_valid(20, edges);
            vectors++; if (edges != 7) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d expected 7", r, edges); end
            check_sample_pop("b2b_sample");
            tick();
            vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle[%0d]: got valid %b busy %b expected 0 0", r, out_valid, busy); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midfill();
        logic [191:0] c;
        int edges;
        chk_ok = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_ctrl: got busy %b valid %b expected 0 0", busy, out_valid); end
        vectors++; if (tries !== 16'd0 || fail !== 1'b0) begin miscompares++; $display("FAIL abort_tries: got tries %0d fail %b expected 0 0", tries, fail); end
        vectors++; if (cand !== '0 || sample !== '0) begin miscompares++; $display("FAIL abort_data: got cand %h sample %h expected 0 0", cand, sample); end
        tick();
        rst_n = 1'b1;
        m_lfsr = 32'hACE1_ACE1;
        gen_cand(c);
        exp_q.push_back(c);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(20, edges);
        vectors++; if (edges != 7) begin miscompares++; $display("FAIL post_reset_latency: got %0d expected 7", edges); end
        vectors++; if (sample[31:0] !== 32'hD650_D673) begin miscompares++; $display("FAIL post_reset_word0: got %h expected d650d673", sample[31:0]); end
        check_sample_pop("post_reset_sample");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seed1_accept();
        test_seed_zero();
        test_fail();
        test_retry();
        test_hold();
        test_back_to_back();
        test_reset_midfill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
